// File: rtl/coreahblite_wrr_slavearbiter.sv
// Weighted round-robin arbiter for one slave port of the 4-master AHB-Lite matrix.
// Per-master credits gate eligibility; a locked sequence keeps the slave until its owner drops the lock.
module coreahblite_wrr_slavearbiter #(
    parameter int unsigned WEIGHT0  = 1,
    parameter int unsigned WEIGHT1  = 1,
    parameter int unsigned WEIGHT2  = 1,
    parameter int unsigned WEIGHT3  = 1,
    parameter int unsigned CREDIT_W = 4
) (
    input  logic       HCLK,
    input  logic       aresetn,
    input  logic [3:0] MREQ,
    input  logic [3:0] MLOCK,
    input  logic       ADDRPHEND,
    output logic [3:0] GRANT,
    output logic       LOCKED,
    output logic [1:0] OWNER
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        EXTEND  = 3'd1,
        LOCK    = 3'd2,
        LOCKEXT = 3'd3,
        RELOAD  = 3'd4
    } state_t;

    localparam int unsigned CREDIT_MAX = (32'd1 << CREDIT_W) - 32'd1;

    // A zero weight would starve its master forever, so it is promoted to one.
    function automatic logic [CREDIT_W-1:0] eff_weight(input int unsigned w);
        int unsigned v;
        if (w == 0)
            v = 1;
        else if (w > CREDIT_MAX)
            v = CREDIT_MAX;
        else
            v = w;
        return v[CREDIT_W-1:0];
    endfunction

    localparam logic [CREDIT_W-1:0] W0 = eff_weight(WEIGHT0);
    localparam logic [CREDIT_W-1:0] W1 = eff_weight(WEIGHT1);
    localparam logic [CREDIT_W-1:0] W2 = eff_weight(WEIGHT2);
    localparam logic [CREDIT_W-1:0] W3 = eff_weight(WEIGHT3);

    state_t              state;
    state_t              next_state;
    logic [1:0]          ptr;
    logic [1:0]          owner_q;
    logic                locked_q;
    logic [CREDIT_W-1:0] credit [4];

    logic [3:0]          elig;
    logic                found;
    logic [1:0]          win;
    logic [1:0]          cand;
    logic [3:0]          grant_c;
    logic                upd_owner;
    logic                set_ptr;
    logic                dec_credit;
    logic [1:0]          sel_idx;
    logic                do_reload;

    // Rotating search starting just after the last master served.
    always_comb begin
        elig  = '0;
        found = 1'b0;
        win   = ptr;
        cand  = ptr;
        for (int n = 0; n < 4; n++)
            elig[n] = MREQ[n] & (credit[n] != '0);
        for (int i = 1; i <= 4; i++) begin
            cand = ptr + 2'(i);
            if (!found && elig[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    always_comb begin
        grant_c    = 4'b0000;
        next_state = IDLE;
        upd_owner  = 1'b0;
        set_ptr    = 1'b0;
        dec_credit = 1'b0;
        sel_idx    = owner_q;
        do_reload  = 1'b0;
        case (state)
            IDLE: begin
                if (found) begin
                    grant_c   = 4'b0001 << win;
                    upd_owner = 1'b1;
                    sel_idx   = win;
                    if (MLOCK[win]) begin
                        next_state = ADDRPHEND ? LOCK : LOCKEXT;
                    end else if (ADDRPHEND) begin
                        next_state = IDLE;
                        dec_credit = 1'b1;
                        set_ptr    = 1'b1;
                    end else begin
                        next_state = EXTEND;
                    end
                end else if (MREQ != 4'b0000) begin
                    next_state = RELOAD;
                end else begin
                    next_state = IDLE;
                end
            end
            EXTEND: begin
                grant_c = 4'b0001 << owner_q;
                if (ADDRPHEND) begin
                    next_state = IDLE;
                    dec_credit = 1'b1;
                    set_ptr    = 1'b1;
                end else begin
                    next_state = EXTEND;
                end
            end
            LOCK: begin
                // Releasing the lock costs a dead cycle so the next winner sees fresh state.
                if (!MLOCK[owner_q]) begin
                    next_state = IDLE;
                    set_ptr    = 1'b1;
                end else if (MREQ[owner_q]) begin
                    grant_c    = 4'b0001 << owner_q;
                    next_state = ADDRPHEND ? LOCK : LOCKEXT;
                end else begin
                    next_state = LOCK;
                end
            end
            LOCKEXT: begin
                grant_c    = 4'b0001 << owner_q;
                next_state = ADDRPHEND ? LOCK : LOCKEXT;
            end
            RELOAD: begin
                do_reload  = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            ptr       <= 2'd3;
            owner_q   <= 2'd3;
            locked_q  <= 1'b0;
            credit[0] <= W0;
            credit[1] <= W1;
            credit[2] <= W2;
            credit[3] <= W3;
        end else begin
            state    <= next_state;
            locked_q <= (next_state == LOCK) || (next_state == LOCKEXT);
            if (upd_owner)
                owner_q <= win;
            if (set_ptr)
                ptr <= sel_idx;
            if (do_reload) begin
                credit[0] <= W0;
                credit[1] <= W1;
                credit[2] <= W2;
                credit[3] <= W3;
            end else if (dec_credit && (credit[sel_idx] != '0)) begin
                credit[sel_idx] <= credit[sel_idx] - CREDIT_W'(1);
            end
        end
    end

    assign GRANT  = aresetn ? grant_c : 4'b0000;
    assign LOCKED = locked_q;
    assign OWNER  = owner_q;

endmodule

// File: tb/tb_coreahblite_wrr_slavearbiter.sv
// Scoreboard bench for the weighted round-robin slave arbiter: expected GRANT/LOCKED/OWNER
// per cycle are queued when stimulus is driven and compared at the following falling edge.
module tb_coreahblite_wrr_slavearbiter;

    logic       HCLK    = 1'b0;
    logic       aresetn = 1'b0;
    logic [3:0] mreq    = 4'b0000;
    logic [3:0] mlock   = 4'b0000;
    logic       ape     = 1'b0;

    logic [3:0] grant_a, grant_b;
    logic       locked_a, locked_b;
    logic [1:0] owner_a, owner_b;

    int total = 0;
    int bad   = 0;
    int step  = 0;

    typedef struct {
        int         sel;
        int         step;
        logic [3:0] grant;
        logic       locked;
        logic [1:0] owner;
    } exp_t;

    exp_t sb[$];

    always #5 HCLK = ~HCLK;

    coreahblite_wrr_slavearbiter dut_a (
        .HCLK      (HCLK),
        .aresetn   (aresetn),
        .MREQ      (mreq),
        .MLOCK     (mlock),
        .ADDRPHEND (ape),
        .GRANT     (grant_a),
        .LOCKED    (locked_a),
        .OWNER     (owner_a)
    );

    coreahblite_wrr_slavearbiter #(
        .WEIGHT0 (3),
        .WEIGHT1 (1),
        .WEIGHT2 (1),
        .WEIGHT3 (1)
    ) dut_b (
        .HCLK      (HCLK),
        .aresetn   (aresetn),
        .MREQ      (mreq),
        .MLOCK     (mlock),
        .ADDRPHEND (ape),
        .GRANT     (grant_b),
        .LOCKED    (locked_b),
        .OWNER     (owner_b)
    );

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Drive one cycle of inputs and queue what the arbiter should show during it.
    task automatic applyStimulus(input int sel, input logic [3:0] m, input logic [3:0] l,
                                 input logic a, input logic [3:0] eg, input logic el,
                                 input logic [1:0] eo);
        exp_t e;
        step++;
        mreq  = m;
        mlock = l;
        ape   = a;
        e.sel    = sel;
        e.step   = step;
        e.grant  = eg;
        e.locked = el;
        e.owner  = eo;
        sb.push_back(e);
        @(posedge HCLK);
        #1;
    endtask

    task automatic doReset();
        mreq    = 4'b0000;
        mlock   = 4'b0000;
        ape     = 1'b0;
        aresetn = 1'b0;
        #1;
        checkOutput("rst_grant_a", {4'b0, grant_a}, 8'h00);
        checkOutput("rst_locked_a", {7'b0, locked_a}, 8'h00);
        checkOutput("rst_owner_a", {6'b0, owner_a}, 8'h03);
        checkOutput("rst_owner_b", {6'b0, owner_b}, 8'h03);
        @(posedge HCLK);
        #1;
        aresetn = 1'b1;
    endtask

    always @(negedge HCLK) begin
        if (sb.size() != 0) begin
            exp_t       e;
            logic [3:0] g;
            logic       lk;
            logic [1:0] ow;
            e  = sb.pop_front();
            g  = (e.sel == 0) ? grant_a  : grant_b;
            lk = (e.sel == 0) ? locked_a : locked_b;
            ow = (e.sel == 0) ? owner_a  : owner_b;
            checkOutput($sformatf("grant s%0d", e.step), {4'b0, g}, {4'b0, e.grant});
            checkOutput($sformatf("locked s%0d", e.step), {7'b0, lk}, {7'b0, e.locked});
            checkOutput($sformatf("owner s%0d", e.step), {6'b0, ow}, {6'b0, e.owner});
            checkOutput($sformatf("onehot s%0d", e.step), {7'b0, $onehot0(g)}, 8'h01);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        @(posedge HCLK);
        #1;

        // Equal weights, everyone requesting: plain rotation, then reload bubble.
        doReset();
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd2);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0);

        // Master 0 weighted 3 against master 1 weighted 1.
        doReset();
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd1);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd1);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0);
        applyStimulus(1, 4'b0011, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0);

        // Wait-stated address phase of master 2 holds the grant.
        doReset();
        applyStimulus(0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd3);
        applyStimulus(0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2);
        applyStimulus(0, 4'b0101, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2);
        applyStimulus(0, 4'b0101, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd2);
        applyStimulus(0, 4'b0101, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd2);

        // Locked sequence of master 1, then release and credit check.
        doReset();
        applyStimulus(0, 4'b0010, 4'b0010, 1'b1, 4'b0010, 1'b0, 2'd3);
        applyStimulus(0, 4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0010, 1'b1, 4'b0010, 1'b1, 2'd1);
        applyStimulus(0, 4'b1101, 4'b0010, 1'b1, 4'b0000, 1'b1, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b0, 2'd1);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd2);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd1);

        // Lone exhausted master 3, idle with a stray ADDRPHEND, then master 0.
        doReset();
        applyStimulus(0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd3);
        applyStimulus(0, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);
        applyStimulus(0, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);
        applyStimulus(0, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd3);
        applyStimulus(0, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd3);
        applyStimulus(0, 4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3);

        // Reset asserted in the middle of master 2's extended address phase.
        doReset();
        applyStimulus(0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd3);
        applyStimulus(0, 4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b0, 2'd2);
        mreq    = 4'b1111;
        aresetn = 1'b0;
        #1;
        checkOutput("midrst_grant", {4'b0, grant_a}, 8'h00);
        checkOutput("midrst_locked", {7'b0, locked_a}, 8'h00);
        checkOutput("midrst_owner", {6'b0, owner_a}, 8'h03);
        @(posedge HCLK);
        #1;
        checkOutput("midrst_grant_held", {4'b0, grant_a}, 8'h00);
        aresetn = 1'b1;
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd3);
        applyStimulus(0, 4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b0, 2'd0);

        @(posedge HCLK);
        #1;
        checkOutput("sb_drain", 8'(sb.size()), 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
